// File: rtl/wasca_trace_pkg.sv
// Shared definitions for the trace recorder: capture state encoding,
// CSR word offsets and CTRL/STATUS bit positions.
package wasca_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int CSR_CTRL       = 0;
    localparam int CSR_STATUS     = 1;
    localparam int CSR_POST_COUNT = 2;
    localparam int CSR_WR_PTR     = 3;
    localparam int CSR_TRIG_PTR   = 4;

    localparam int CTRL_ARM_BIT    = 0;
    localparam int CTRL_STOP_BIT   = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STAT_WRAPPED_BIT   = 2;
    localparam int STAT_TRIGGERED_BIT = 3;
    localparam int STAT_IRQ_EN_BIT    = 4;

endpackage

// File: rtl/wasca_trace_dpram.sv
// Simple dual-port RAM for the trace buffer: port A writes captured samples,
// port B is a registered read (latency 1) that holds its output when idle.
module wasca_trace_dpram #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9
) (
    input  logic              i_clk,
    input  logic              i_we_a,
    input  logic [ADDR_W-1:0] i_addr_a,
    input  logic [DATA_W-1:0] i_wdata_a,
    input  logic              i_re_b,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic [DATA_W-1:0] o_rdata_b
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Capture write port.
    always_ff @(posedge i_clk) begin
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_wdata_a;
        end
    end

    // Slave read port; output register only updates on a read so it holds.
    always_ff @(posedge i_clk) begin
        if (i_re_b) begin
            o_rdata_b <= r_mem[i_addr_b];
        end
    end

endmodule

// File: rtl/wasca_trace_recorder.sv
// Trace recorder: circular capture of trace_data on trace_valid, stopping a
// programmable number of samples after a trigger. Buffer and CSRs share one
// Avalon-MM slave (address MSB selects CSR space), read latency 1.
// Optional build macro WASCA_TRACE_TIMESTAMP_EN replaces the top TS_W bits of
// each stored word with a free-running timestamp.
module wasca_trace_recorder
    import wasca_trace_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9,
    parameter int TS_W   = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_trace_valid,
    input  logic [DATA_W-1:0]   i_trace_data,
    input  logic                i_trigger,
    input  logic [ADDR_W:0]     i_address,
    input  logic                i_chipselect,
    input  logic                i_read,
    input  logic                i_write,
    input  logic [DATA_W/8-1:0] i_byteenable,
    input  logic [DATA_W-1:0]   i_writedata,
    output logic [DATA_W-1:0]   o_readdata,
    output logic                o_irq
);
    trace_state_e      r_state;
    logic [ADDR_W-1:0] r_wr_ptr, r_trig_ptr, r_post_cnt, r_post_count;
    logic              r_wrapped, r_triggered, r_irq_en, r_irq;
    logic              r_rd_csr;
    logic [DATA_W-1:0] r_csr_rdata;

    logic [DATA_W-1:0] w_be_mask, w_wdata_m, w_csr_rdata, w_cap_data, w_ram_q;
    logic              w_ctrl_wr, w_pc_wr, w_arm, w_stop_eff, w_arm_go, w_cap_we, w_ram_re;
    logic              w_unused;

    assign w_unused = ^{i_writedata, i_trace_data};

    // Expand byte lanes into a bit mask for CSR writes.
    always_comb begin
        w_be_mask = '0;
        for (int b = 0; b < DATA_W/8; b++) begin
            w_be_mask[b*8 +: 8] = {8{i_byteenable[b]}};
        end
    end

    assign w_wdata_m  = i_writedata & w_be_mask;
    assign w_ctrl_wr  = i_chipselect & i_write & (i_address == {1'b1, ADDR_W'(CSR_CTRL)});
    assign w_pc_wr    = i_chipselect & i_write & (i_address == {1'b1, ADDR_W'(CSR_POST_COUNT)});
    assign w_arm      = w_ctrl_wr & w_wdata_m[CTRL_ARM_BIT];
    // STOP only acts outside IDLE, but it also overrides an ARM in the same write.
    assign w_stop_eff = w_ctrl_wr & w_wdata_m[CTRL_STOP_BIT] & ((r_state != ST_IDLE) | w_arm);
    assign w_arm_go   = w_arm & ~w_stop_eff;
    // A control command owns the cycle; no sample is captured alongside it.
    assign w_cap_we   = ((r_state == ST_ARMED) | (r_state == ST_POST)) & i_trace_valid
                        & ~w_stop_eff & ~w_arm_go;
    assign w_ram_re   = i_chipselect & i_read & ~i_address[ADDR_W];

`ifdef WASCA_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    // Free-running timestamp, wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    assign w_cap_data = {r_ts, i_trace_data[DATA_W-TS_W-1:0]};
`else
    assign w_cap_data = i_trace_data;
`endif

    wasca_trace_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .i_clk     (i_clk),
        .i_we_a    (w_cap_we),
        .i_addr_a  (r_wr_ptr),
        .i_wdata_a (w_cap_data),
        .i_re_b    (w_ram_re),
        .i_addr_b  (i_address[ADDR_W-1:0]),
        .o_rdata_b (w_ram_q)
    );

    // Capture state machine with write pointer, trigger pointer and post counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_post_cnt  <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
        end else if (w_stop_eff) begin
            r_state <= ST_DONE;
        end else if (w_arm_go) begin
            r_state     <= ST_ARMED;
            r_wr_ptr    <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_post_cnt  <= r_post_count;
        end else begin
            if (w_cap_we) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                if (r_wr_ptr == {ADDR_W{1'b1}}) begin
                    r_wrapped <= 1'b1;
                end
            end
            case (r_state)
                ST_ARMED: begin
                    if (i_trigger) begin
                        // Same address whether or not this cycle carries a sample.
                        r_trig_ptr  <= r_wr_ptr;
                        r_triggered <= 1'b1;
                        r_state     <= (r_post_cnt == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (i_trace_valid) begin
                        r_post_cnt <= r_post_cnt - ADDR_W'(1);
                        if (r_post_cnt == ADDR_W'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Writable CSR fields: POST_COUNT and IRQ_EN, honouring byte lanes.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_post_count <= '0;
            r_irq_en     <= 1'b0;
        end else begin
            if (w_pc_wr) begin
                r_post_count <= (r_post_count & ~w_be_mask[ADDR_W-1:0]) | w_wdata_m[ADDR_W-1:0];
            end
            if (w_ctrl_wr & i_byteenable[0]) begin
                r_irq_en <= i_writedata[CTRL_IRQ_EN_BIT];
            end
        end
    end

    // Level interrupt one cycle behind DONE & IRQ_EN, dropped by a new ARM.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_irq <= 1'b0;
        end else if (w_arm_go) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (r_state == ST_DONE) & r_irq_en;
        end
    end

    // CSR read mux.
    always_comb begin
        w_csr_rdata = '0;
        case (i_address[ADDR_W-1:0])
            ADDR_W'(CSR_STATUS): begin
                w_csr_rdata[1:0]                = r_state;
                w_csr_rdata[STAT_WRAPPED_BIT]   = r_wrapped;
                w_csr_rdata[STAT_TRIGGERED_BIT] = r_triggered;
                w_csr_rdata[STAT_IRQ_EN_BIT]    = r_irq_en;
            end
            ADDR_W'(CSR_POST_COUNT): w_csr_rdata[ADDR_W-1:0] = r_post_count;
            ADDR_W'(CSR_WR_PTR):     w_csr_rdata[ADDR_W-1:0] = r_wr_ptr;
            ADDR_W'(CSR_TRIG_PTR):   w_csr_rdata[ADDR_W-1:0] = r_trig_ptr;
            default:                 w_csr_rdata = '0;
        endcase
    end

    // Registered CSR read data and source select; held until the next read.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_csr    <= 1'b1;
            r_csr_rdata <= '0;
        end else if (i_chipselect & i_read) begin
            r_rd_csr    <= i_address[ADDR_W];
            r_csr_rdata <= w_csr_rdata;
        end else begin
            r_rd_csr    <= r_rd_csr;
            r_csr_rdata <= r_csr_rdata;
        end
    end

    assign o_readdata = r_rd_csr ? r_csr_rdata : w_ram_q;
    assign o_irq      = r_irq;

endmodule

// File: tb/tb_wasca_trace_recorder.sv
// Self-checking bench for wasca_trace_recorder (ADDR_W=4). Directed test-plan
// scenarios plus randomized capture sessions compared against a sample-count
// based reference model.
module tb_wasca_trace_recorder;
    localparam int DW = 64;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DONE = 3;

    logic          i_clk = 1'b0;
    logic          i_reset, i_trace_valid, i_trigger, i_chipselect, i_read, i_write;
    logic [DW-1:0] i_trace_data, i_writedata;
    logic [AW:0]   i_address;
    logic [7:0]    i_byteenable;
    logic [DW-1:0] o_readdata;
    logic          o_irq;

    wasca_trace_recorder #(.DATA_W(DW), .ADDR_W(AW), .TS_W(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_trace_valid(i_trace_valid),
        .i_trace_data(i_trace_data), .i_trigger(i_trigger), .i_address(i_address),
        .i_chipselect(i_chipselect), .i_read(i_read), .i_write(i_write),
        .i_byteenable(i_byteenable), .i_writedata(i_writedata),
        .o_readdata(o_readdata), .o_irq(o_irq)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model: capture measured as a count of samples since ARM.
    int          m_state, m_count, m_trig, m_post_left, m_post_count;
    bit          m_triggered, m_irq_en, m_irq;
    logic [63:0] m_rdata;
    logic [63:0] m_mem [DEPTH];
    logic [15:0] m_ts;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] csr_val(input int off);
        case (off)
            1:       csr_val = 64'(m_irq_en) << 4 | 64'(m_triggered) << 3 |
                               64'(m_count >= DEPTH) << 2 | 64'(m_state);
            2:       csr_val = 64'(m_post_count);
            3:       csr_val = 64'(m_count % DEPTH);
            4:       csr_val = 64'(m_trig);
            default: csr_val = 64'd0;
        endcase
    endfunction

    task automatic store(input logic [63:0] d);
`ifdef WASCA_TRACE_TIMESTAMP_EN
        m_mem[m_count % DEPTH] = {m_ts, d[47:0]};
`else
        m_mem[m_count % DEPTH] = d;
`endif
        m_count++;
    endtask

    // Drive one clock cycle of inputs and advance the model by the same cycle.
    task automatic cycle(input bit v, input logic [63:0] d, input bit trg, input bit cs,
                         input bit rd, input bit wr, input logic [4:0] a,
                         input logic [7:0] be, input logic [63:0] wd);
        bit ctrl, arm, stop, stop_eff, irq_next;
        i_trace_valid = v; i_trace_data = d; i_trigger = trg; i_chipselect = cs;
        i_read = rd; i_write = wr; i_address = a; i_byteenable = be; i_writedata = wd;
        if (cs && rd) m_rdata = a[4] ? csr_val(int'(a[3:0])) : m_mem[a[3:0]];
        irq_next = (m_state == S_DONE) && m_irq_en;
        ctrl = cs && wr && (a == 5'h10);
        arm  = ctrl && be[0] && wd[0];
        stop = ctrl && be[0] && wd[1];
        stop_eff = stop && (m_state != S_IDLE || arm);
        if (ctrl && be[0]) m_irq_en = wd[2];
        if (cs && wr && a == 5'h12 && be[0]) m_post_count = int'(wd[3:0]);
        if (stop_eff) begin
            m_state = S_DONE;
        end else if (arm) begin
            m_state = S_ARMED; m_count = 0; m_triggered = 0; m_post_left = m_post_count;
        end else if (m_state == S_ARMED) begin
            if (trg) begin
                m_trig = m_count % DEPTH; m_triggered = 1;
                m_state = (m_post_left == 0) ? S_DONE : S_POST;
            end
            if (v) store(d);
        end else if (m_state == S_POST && v) begin
            store(d);
            m_post_left--;
            if (m_post_left == 0) m_state = S_DONE;
        end
        m_irq = (arm && !stop_eff) ? 1'b0 : irq_next;
        m_ts++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic smp(input bit v, input logic [63:0] d, input bit trg);
        cycle(v, d, trg, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 64'd0);
        check("irq", 64'(o_irq), 64'(m_irq));
    endtask

    task automatic csr_wr(input int off, input logic [63:0] d, input logic [7:0] be);
        cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'(16 + off), be, d);
    endtask

    task automatic rd(input logic [4:0] a);
        cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, a, 8'd0, 64'd0);
    endtask

    task automatic rd_model(input string tag, input logic [4:0] a);
        rd(a);
        check(tag, o_readdata, m_rdata);
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 64'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 64'd0);
        i_reset = 1'b0;
        m_state = S_IDLE; m_count = 0; m_trig = 0; m_post_left = 0; m_post_count = 0;
        m_triggered = 0; m_irq_en = 0; m_irq = 0; m_rdata = 64'd0; m_ts = 16'd0;
    endtask

    initial begin
        logic [63:0] w0, w1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'd0;
        do_reset();
        check("reset_irq", 64'(o_irq), 64'd0);
        check("reset_rdata", o_readdata, 64'd0);
        rd(5'h11); check("reset_status", o_readdata, 64'd0);
        rd(5'h13); check("reset_wrptr", o_readdata, 64'd0);

        // POST_COUNT=3, 5 pre-samples, trigger with sample 5, 3 post samples.
        csr_wr(2, 64'd3, 8'hFF);
        csr_wr(0, 64'd1, 8'hFF);
        for (int i = 0; i < 5; i++) smp(1'b1, 64'(i), 1'b0);
        smp(1'b1, 64'd5, 1'b1);
        for (int i = 6; i < 9; i++) smp(1'b1, 64'(i), 1'b0);
        smp(1'b1, 64'd99, 1'b0);
        rd(5'h11); check("a_status", o_readdata, 64'h0B);
        rd(5'h14); check("a_trigptr", o_readdata, 64'd5);
        rd(5'h13); check("a_wrptr", o_readdata, 64'd9);
        for (int i = 5; i < 9; i++) begin
            rd(5'(i)); check("a_mem", 64'(o_readdata[31:0]), 64'(i));
        end

        // POST_COUNT=2, 20 pre-samples then trigger: wraps.
        csr_wr(2, 64'd2, 8'hFF);
        csr_wr(0, 64'd1, 8'hFF);
        for (int i = 0; i < 20; i++) smp(1'b1, 64'(i), 1'b0);
        smp(1'b1, 64'd20, 1'b1);
        smp(1'b1, 64'd21, 1'b0);
        smp(1'b1, 64'd22, 1'b0);
        rd(5'h11); check("b_status", o_readdata, 64'h0F);
        rd(5'h13); check("b_wrptr", o_readdata, 64'd7);
        rd(5'h07); check("b_oldest", 64'(o_readdata[31:0]), 64'd7);
        rd(5'h06); check("b_newest_minus", 64'(o_readdata[31:0]), 64'd22);

        // POST_COUNT=0, trigger without sample at wr_ptr=3, irq enabled.
        csr_wr(2, 64'd0, 8'hFF);
        csr_wr(0, 64'd5, 8'hFF);
        for (int i = 0; i < 3; i++) smp(1'b1, 64'(100 + i), 1'b0);
        smp(1'b0, 64'd0, 1'b1);
        check("c_irq_early", 64'(o_irq), 64'd0);
        rd(5'h11); check("c_status", o_readdata, 64'h1B);
        check("c_irq_set", 64'(o_irq), 64'd1);
        rd(5'h14); check("c_trigptr", o_readdata, 64'd3);
        csr_wr(0, 64'd5, 8'hFF);
        check("c_irq_cleared", 64'(o_irq), 64'd0);

        // STOP in ARMED, then ARM+STOP together, then reset during POST.
        csr_wr(0, 64'd1, 8'hFF);
        smp(1'b1, 64'd1, 1'b0);
        smp(1'b1, 64'd2, 1'b0);
        csr_wr(0, 64'd2, 8'hFF);
        rd(5'h11); check("d_stop_status", o_readdata, 64'h03);
        csr_wr(0, 64'd3, 8'hFF);
        rd(5'h11); check("d_armstop_status", o_readdata, 64'h03);
        rd(5'h13); check("d_armstop_wrptr", o_readdata, 64'd2);
        csr_wr(2, 64'd5, 8'hFF);
        csr_wr(0, 64'd1, 8'hFF);
        smp(1'b1, 64'd1, 1'b0);
        smp(1'b1, 64'd2, 1'b1);
        smp(1'b1, 64'd3, 1'b0);
        rd(5'h11); check("d_post_status", o_readdata, 64'h0A);
        do_reset();
        check("d_reset_rdata", o_readdata, 64'd0);
        rd(5'h11); check("d_reset_status", o_readdata, 64'd0);
        rd(5'h13); check("d_reset_wrptr", o_readdata, 64'd0);

        // Byte lanes on POST_COUNT; buffer writes are ignored.
        csr_wr(2, 64'd9, 8'h00);
        rd(5'h12); check("be_masked", o_readdata, 64'd0);
        csr_wr(2, 64'd9, 8'h01);
        rd(5'h12); check("be_lane0", o_readdata, 64'd9);
        rd(5'h10); check("ctrl_reads0", o_readdata, 64'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'h03, 8'hFF, 64'hDEAD);
        rd_model("buf_write_ignored", 5'h03);

        // Randomized capture sessions against the model.
        for (int it = 0; it < 30; it++) begin
            int n;
            csr_wr(2, 64'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'hFF);
            csr_wr(0, 64'(1 | ($urandom_range(0, 1) << 2)), 8'hFF);
            n = $urandom_range(5, 60);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 40) == 0)
                    csr_wr(0, 64'($urandom_range(0, 7)), 8'hFF);
                else
                    smp($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 12) == 0);
            end
            for (int k = 0; k < 5; k++) rd_model("r_csr", 5'(16 + k));
            for (int k = 0; k < DEPTH; k++) rd_model("r_mem", 5'(k));
            smp(1'b0, 64'd0, 1'b0);
            check("r_rdata_hold", o_readdata, m_rdata);
        end

`ifdef WASCA_TRACE_TIMESTAMP_EN
        // Two samples four cycles apart carry timestamps four apart.
        csr_wr(2, 64'd10, 8'hFF);
        csr_wr(0, 64'd1, 8'hFF);
        smp(1'b1, 64'h1, 1'b0);
        smp(1'b0, 64'h0, 1'b0);
        smp(1'b0, 64'h0, 1'b0);
        smp(1'b0, 64'h0, 1'b0);
        smp(1'b1, 64'h2, 1'b0);
        rd(5'h00); w0 = o_readdata;
        rd(5'h01); w1 = o_readdata;
        check("ts_delta", 64'(w1[63:48] - w0[63:48]), 64'd4);
`else
        w0 = 64'd0; w1 = 64'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
